// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: state encodings and command bytes shared by
// the PS/2 host transmit path and the code that drives it.
package ps2_host_tx_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] WAIT_ACK  = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;
    localparam logic [2:0] ERROR     = 3'd7;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

    function automatic logic oddParity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_line_filter: glitch filter for one PS/2 pad line.
// Ports: Clock, Reset (async low), iLine raw pad, oLevel filtered
// level, oFall one-cycle pulse on a filtered 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iLine,
    output logic oLevel,
    output logic oFall
);

    logic [FILTER_LEN-1:0] shiftReg;

    // Preset high so a released bus reads as idle out of reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            shiftReg <= '1;
            oLevel   <= 1'b1;
            oFall    <= 1'b0;
        end else begin
            shiftReg <= {shiftReg[FILTER_LEN-2:0], iLine};
            oFall    <= 1'b0;
            if (&shiftReg) begin
                oLevel <= 1'b1;
            end else if (~|shiftReg) begin
                oLevel <= 1'b0;
                oFall  <= oLevel;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device.
// Ports: Clock, Reset (async low), iStart strobe, iData byte,
// iPS2Clk/iPS2Data raw pads, oPS2ClkLow/oPS2DataLow open-drain
// pull-downs, oBusy, oDone and oError one-cycle result pulses.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic [7:0] iData,
    input  logic       iPS2Clk,
    input  logic       iPS2Data,
    output logic       oPS2ClkLow,
    output logic       oPS2DataLow,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                             INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [7:0]    txByte;
    logic          parity;
    logic [3:0]    bitCnt;
    logic [CW-1:0] cnt;
    logic          clkLevel;
    logic          clkFall;
    logic          dataLevel;
    logic          dataFall;
    logic          timeout;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) clkFilter (
        .Clock  (Clock),
        .Reset  (Reset),
        .iLine  (iPS2Clk),
        .oLevel (clkLevel),
        .oFall  (clkFall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) dataFilter (
        .Clock  (Clock),
        .Reset  (Reset),
        .iLine  (iPS2Data),
        .oLevel (dataLevel),
        .oFall  (dataFall)
    );

    assign timeout = (cnt == TMO_LAST);

    // cnt doubles as the inhibit timer and the device timeout.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            txByte      <= '0;
            parity      <= 1'b0;
            bitCnt      <= '0;
            cnt         <= '0;
            oPS2ClkLow  <= 1'b0;
            oPS2DataLow <= 1'b0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oError      <= 1'b0;
        end else begin
            oDone  <= 1'b0;
            oError <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        txByte     <= iData;
                        parity     <= oddParity(iData);
                        oBusy      <= 1'b1;
                        oPS2ClkLow <= 1'b1;
                        cnt        <= '0;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        oPS2DataLow <= 1'b1;
                        state       <= REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REQ: begin
                    oPS2ClkLow <= 1'b0;
                    bitCnt     <= '0;
                    cnt        <= '0;
                    state      <= SEND;
                end
                SEND: begin
                    if (clkFall) begin
                        cnt    <= '0;
                        bitCnt <= bitCnt + 1'b1;
                        if (bitCnt < 4'd8) begin
                            oPS2DataLow <= ~txByte[bitCnt[2:0]];
                        end else if (bitCnt == 4'd8) begin
                            oPS2DataLow <= ~parity;
                        end else begin
                            oPS2DataLow <= 1'b0;
                            state       <= WAIT_ACK;
                        end
                    end else if (timeout) begin
                        state <= ERROR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (clkFall) begin
                        cnt   <= '0;
                        state <= dataLevel ? ERROR : WAIT_IDLE;
                    end else if (timeout) begin
                        state <= ERROR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (clkLevel && dataLevel) begin
                        state <= DONE;
                    end else if (clkFall) begin
                        cnt <= '0;
                    end else if (timeout) begin
                        state <= ERROR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                ERROR: begin
                    oPS2ClkLow  <= 1'b0;
                    oPS2DataLow <= 1'b0;
                    oError      <= 1'b1;
                    oBusy       <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unusedFall;
    assign unusedFall = dataFall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model plus scoreboard for ps2_host_tx.
// Frames, timeout, missing ack, mid-frame reset, ignored restart.
module tb_ps2_host_tx;

    localparam int FL  = 4;
    localparam int INH = 200;
    localparam int TMO = 2000;
    localparam int HP  = 30;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iStart = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oPS2ClkLow;
    logic       oPS2DataLow;
    logic       oBusy;
    logic       oDone;
    logic       oError;
    logic       devClkLow = 1'b0;
    logic       devDataLow = 1'b0;
    logic       busClk;
    logic       busData;

    assign busClk  = ~(oPS2ClkLow | devClkLow);
    assign busData = ~(oPS2DataLow | devDataLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FL)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iStart      (iStart),
        .iData       (iData),
        .iPS2Clk     (busClk),
        .iPS2Data    (busData),
        .oPS2ClkLow  (oPS2ClkLow),
        .oPS2DataLow (oPS2DataLow),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oError      (oError)
    );

    always #5 Clock = ~Clock;

    int   checks = 0;
    int   errors = 0;
    logic expQ[$];

    int   doneCnt = 0;
    int   errCnt = 0;
    bit   both = 1'b0;
    bit   busyBad = 1'b0;
    logic prevBusy = 1'b0;

    always @(negedge Clock) begin
        if (Reset) begin
            if (oDone) doneCnt++;
            if (oError) errCnt++;
            if (oDone && oError) both = 1'b1;
            if ((oDone || oError) && (oBusy || !prevBusy))
                busyBad = 1'b1;
        end
        prevBusy = oBusy;
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h",
                     name, act, exp);
        end
    endtask

    task automatic pushFrame(input logic [7:0] d, input logic par);
        expQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) expQ.push_back(d[i]);
        expQ.push_back(par);
        expQ.push_back(1'b1);
    endtask

    task automatic sampleBit(input string tag);
        logic e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_bit actual %0d required none",
                     tag, busData);
        end else begin
            e = expQ.pop_front();
            check({tag, "_bit"}, 32'(busData), 32'(e));
        end
    endtask

    task automatic startTx(input logic [7:0] d);
        @(negedge Clock);
        iData  = d;
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        check("busy_after_start", 32'(oBusy), 1);
    endtask

    // Device side: times the inhibit, checks the start bit, then
    // clocks out `pulses` bits and optionally acks on pulse 11.
    task automatic device(input bit ack, input int pulses,
                          input string tag);
        int n;
        n = 0;
        while (!oPS2ClkLow && n < 100) begin
            @(negedge Clock);
            n++;
        end
        n = 0;
        while (oPS2ClkLow && n < INH + 50) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_inhibit"},
              32'(n >= INH && n <= INH + 2), 1);
        check({tag, "_start_bus"}, 32'(busData), 0);
        repeat (HP) @(negedge Clock);
        sampleBit(tag);
        for (int k = 1; k <= pulses; k++) begin
            devClkLow = 1'b1;
            repeat (HP) @(negedge Clock);
            devClkLow = 1'b0;
            if (k <= 10) sampleBit(tag);
            repeat (5) @(negedge Clock);
            if (k == 10 && ack) devDataLow = 1'b1;
            repeat (HP - 5) @(negedge Clock);
            if (k == 11) devDataLow = 1'b0;
        end
    endtask

    task automatic waitEnd(input int d0, input int e0,
                           input int expD, input int expE,
                           input string tag);
        int n;
        n = 0;
        while (doneCnt + errCnt == d0 + e0 && n < 400) begin
            @(negedge Clock);
            n++;
        end
        repeat (20) @(negedge Clock);
        check({tag, "_done"}, 32'(doneCnt - d0), 32'(expD));
        check({tag, "_error"}, 32'(errCnt - e0), 32'(expE));
        check({tag, "_busy_end"}, 32'(oBusy), 0);
        check({tag, "_lines_rel"},
              32'({oPS2ClkLow, oPS2DataLow}), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         ack;
        int         expDone;
        int         expErr;
        string      tag;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int d0;
        int e0;
        int n;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0, "setled"};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1, 0, "byte01"};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1, 0, "byte00"};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 0, 1, "noack"};

        repeat (3) @(negedge Clock);
        check("rst_clklow", 32'(oPS2ClkLow), 0);
        check("rst_datalow", 32'(oPS2DataLow), 0);
        check("rst_busy", 32'(oBusy), 0);
        check("rst_done", 32'(oDone), 0);
        check("rst_error", 32'(oError), 0);
        Reset = 1'b1;
        repeat (FL + 4) @(negedge Clock);

        for (int v = 0; v < 4; v++) begin
            d0 = doneCnt;
            e0 = errCnt;
            pushFrame(vecs[v].data, vecs[v].par);
            startTx(vecs[v].data);
            device(vecs[v].ack, 11, vecs[v].tag);
            waitEnd(d0, e0, vecs[v].expDone, vecs[v].expErr,
                    vecs[v].tag);
            check({vecs[v].tag, "_sb_left"}, 32'(expQ.size()), 0);
        end

        // Device never clocks after the request.
        d0 = doneCnt;
        e0 = errCnt;
        startTx(8'h3C);
        n = 0;
        while (oPS2ClkLow && n < INH + 50) begin
            @(negedge Clock);
            n++;
        end
        n = 0;
        while (!oError && n < TMO + 100) begin
            @(negedge Clock);
            n++;
        end
        check("tmo_cycles", 32'(n >= TMO && n <= TMO + 3), 1);
        check("tmo_lines", 32'({oPS2ClkLow, oPS2DataLow}), 0);
        waitEnd(d0, e0, 0, 1, "tmo");

        // Reset while D4 (a zero) is on the bus.
        d0 = doneCnt;
        e0 = errCnt;
        pushFrame(8'hE5, 1'b0);
        startTx(8'hE5);
        device(1'b0, 4, "rstmid");
        devClkLow = 1'b1;
        repeat (HP / 2) @(negedge Clock);
        check("rstmid_d4_low", 32'(oPS2DataLow), 1);
        Reset = 1'b0;
        #1;
        check("rstmid_lines", 32'({oPS2ClkLow, oPS2DataLow}), 0);
        check("rstmid_busy", 32'(oBusy), 0);
        expQ.delete();
        @(negedge Clock);
        devClkLow = 1'b0;
        repeat (5) @(negedge Clock);
        Reset = 1'b1;
        repeat (FL + 4) @(negedge Clock);
        check("rstmid_no_done", 32'(doneCnt - d0), 0);
        check("rstmid_no_err", 32'(errCnt - e0), 0);

        d0 = doneCnt;
        e0 = errCnt;
        pushFrame(8'hFF, 1'b1);
        startTx(8'hFF);
        device(1'b1, 11, "after_rst");
        waitEnd(d0, e0, 1, 0, "after_rst");

        // Second strobe with another byte mid-frame is ignored.
        d0 = doneCnt;
        e0 = errCnt;
        pushFrame(8'h5A, 1'b1);
        startTx(8'h5A);
        fork
            device(1'b1, 11, "ignore");
            begin
                repeat (100) @(negedge Clock);
                check("ignore_busy_mid", 32'(oBusy), 1);
                iData  = 8'hC3;
                iStart = 1'b1;
                @(negedge Clock);
                iStart = 1'b0;
            end
        join
        waitEnd(d0, e0, 1, 0, "ignore");
        check("ignore_sb_left", 32'(expQ.size()), 0);

        check("done_error_overlap", 32'(both), 0);
        check("busy_fall_with_pulse", 32'(busyBad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It is the counterpart of the keyboard receive path (serial2parallel): it sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). The MiniAlu control logic starts it with a one-cycle strobe. It drives the PS/2 clock and data lines through open-drain low-enables, and it reports done or error.

Parameters:
INHIBIT_CYCLES, 5000, cycles the clock line is held low before the request (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, maximum cycles to wait for any device clock edge or the ack phase (20 ms at 50 MHz).
FILTER_LEN, 8, depth of the input glitch filter on the PS/2 clock and data lines.

Ports:
Clock  in  1  system clock, 50 MHz.
Reset  in  1  asynchronous, active-low reset.
iStart  in  1  one-cycle strobe; accepted only when oBusy=0.
iData  in  8  command byte; latched on an accepted iStart.
iPS2Clk  in  1  raw PS/2 clock line (pad input).
iPS2Data  in  1  raw PS/2 data line (pad input).
oPS2ClkLow  out  1  1 = pull the PS/2 clock pad low; 0 = release (high-Z).
oPS2DataLow  out  1  1 = pull the PS/2 data pad low; 0 = release (high-Z).
oBusy  out  1  high from the accepted iStart until oDone or oError.
oDone  out  1  one-cycle pulse: byte sent and device ack seen.
oError  out  1  one-cycle pulse: timeout or missing ack.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE, all outputs 0, both lines released.
  - Filter shift registers are preset to all-ones, so a released bus reads high.
- Input filter:
  - Each line goes through a FILTER_LEN shift register.
  - The filtered level becomes 1 when all bits are 1, becomes 0 when all bits are 0, and otherwise holds.
  - A falling edge is filtered 1 -> 0 (one-cycle pulse). Filter latency is FILTER_LEN cycles.
- Frame: start(0), D0..D7 LSB first, odd parity, stop(1), device ack(0). Parity = ~^iData.
- FSM:
  - IDLE: on iStart, latch iData, compute parity, go to INHIBIT. oBusy goes high the following cycle.
  - INHIBIT: oPS2ClkLow=1 for INHIBIT_CYCLES, then go to REQ.
  - REQ: oPS2DataLow=1 (start bit) with the clock still held for 1 cycle, then release the clock and go to SEND. Clear the bit counter and the timeout counter.
  - SEND, on each filtered falling clock edge, by bit count n:
    - n=0..7: drive D[n] (oPS2DataLow=~D[n]).
    - n=8: drive parity.
    - n=9: release data (stop bit), then go to WAIT_ACK.
  - WAIT_ACK: on the next falling edge, sample filtered data.
    - 0 -> WAIT_IDLE.
    - 1 -> ERROR.
  - WAIT_IDLE: wait until filtered clock and data are both 1, then DONE.
  - DONE: pulse oDone, go to IDLE.
  - ERROR: release both lines, pulse oError, go to IDLE.
- Timeout counter:
  - Runs in SEND, WAIT_ACK and WAIT_IDLE.
  - Cleared on every filtered falling clock edge.
  - Reaching TIMEOUT_CYCLES -> ERROR.
- iStart while oBusy=1 is ignored. The latched byte does not change mid-frame.
- oDone and oError are never high together; each is high for exactly 1 cycle per frame.
- Reset asserted mid-frame: both lines are released immediately (async). No oDone or oError pulse is produced.
- The receiver must ignore bus traffic while oBusy=1. The integrating logic gates the receive path with oBusy.

Decomposition:
- Shared package or defines include: state encodings (IDLE, INHIBIT, REQ, SEND, WAIT_ACK, WAIT_IDLE, DONE, ERROR) and the command constants PS2_CMD_SETLED=8'hED and PS2_CMD_RESET=8'hFF.
- One sub-module: ps2_line_filter (FILTER_LEN shift register, level output, falling-edge pulse). It is instantiated twice, and the receive path reuses it.

Test Plan:
1. iStart, iData=8'hED, device model clocks at 12.5 kHz and acks. Required:
   - clock held low ≥5000 cycles, then start bit 0;
   - data bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
   - oDone pulses once; oBusy falls on the same cycle.
2. iData=8'h01 -> parity bit 0. iData=8'h00 -> parity bit 1. The device model checks the frame and acks; oDone each time.
3. Device never clocks after the request -> oError pulses at TIMEOUT_CYCLES after clock release. Lines are released; oDone is never asserted.
4. Device leaves data high at the ack clock -> oError pulses after the 11th falling edge.
5. Reset=0 during bit 4 -> oPS2ClkLow=oPS2DataLow=0 within the same cycle and state=IDLE. A new iStart=8'hFF after reset completes with oDone.
6. A second iStart during a frame with a different byte -> ignored. The transmitted bits match the first byte, and exactly one oDone is produced.
